counter_sequencer: RTL and testbench

Control FSM that sequences an `N`-bit up-counter datapath (`clk`/`rst`/`en`/`count`) as a programmable interval timer. It drives the counter's enable and a synchronous clear, and watches the counter's `count`. It produces a terminal-count `tick`, plus a `done` pulse in one-shot mode. It sits between software-style start/stop requests and the raw counter instance; the bench instantiates both.

---
 rtl/counter_sequencer_if.sv | 25 ++
 rtl/counter_sequencer.sv | 105 ++++++++++
 tb/tb_counter_sequencer.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/counter_sequencer_if.sv
// Request/status bundle between software-side control, the sequencer and the raw up-counter.
// The slave side is the sequencer. The master side is whoever issues requests and owns the counter.
interface counter_sequencer_if #(parameter int N = 8);
    logic         start;
    logic         stop;
    logic [N-1:0] period;
    logic         periodic;
    logic [N-1:0] count;
    logic         cnt_en;
    logic         cnt_clr;
    logic         busy;
    logic         tick;
    logic         done;
    logic         err;

    modport slave (
        input  start, stop, period, periodic, count,
        output cnt_en, cnt_clr, busy, tick, done, err
    );

    modport master (
        output start, stop, period, periodic, count,
        input  cnt_en, cnt_clr, busy, tick, done, err
    );
endinterface

// File: rtl/counter_sequencer.sv
// Programmable interval timer control: sequences an external N-bit up-counter for
// one-shot or auto-reload intervals.
//
// state   | meaning
// S_IDLE  | waiting for an accepted start; all outputs low
// S_CLEAR | one cycle clearing the counter before the interval begins
// S_RUN   | counting; terminal cycle raises tick (reload or finish)
// S_DONE  | one-shot finished; done pulse for one cycle
module counter_sequencer #(
    parameter int N = 8
) (
    input logic               i_clk,
    input logic               i_rst,
    counter_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t       r_state;
    logic [N-1:0] r_period;
    logic         r_periodic;
    logic         r_err;

    logic w_term;
    logic w_cnt_en;
    logic w_cnt_clr;
    logic w_busy;
    logic w_tick;
    logic w_done;

    // r_period is never 0 in RUN, so the N-bit subtraction cannot wrap.
    assign w_term = (bus.count == (r_period - N'(1)));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_period   <= '0;
            r_periodic <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start && !bus.stop) begin
                        if (bus.period != '0) begin
                            r_period   <= bus.period;
                            r_periodic <= bus.periodic;
                            r_state    <= S_CLEAR;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_CLEAR: r_state <= bus.stop ? S_IDLE : S_RUN;
                S_RUN: begin
                    if (bus.stop)
                        r_state <= S_IDLE;
                    else if (w_term && !r_periodic)
                        r_state <= S_DONE;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Counter controls depend on the live count, so they are decoded rather than registered.
    always_comb begin
        w_cnt_en  = 1'b0;
        w_cnt_clr = 1'b0;
        w_busy    = 1'b0;
        w_tick    = 1'b0;
        w_done    = 1'b0;
        case (r_state)
            S_CLEAR: begin
                w_busy    = 1'b1;
                w_cnt_clr = !bus.stop;
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (!bus.stop) begin
                    if (w_term) begin
                        w_tick    = 1'b1;
                        w_cnt_clr = r_periodic;
                    end else begin
                        w_cnt_en = 1'b1;
                    end
                end
            end
            S_DONE:  w_done = 1'b1;
            default: ;
        endcase
    end

    assign bus.cnt_en  = w_cnt_en;
    assign bus.cnt_clr = w_cnt_clr;
    assign bus.busy    = w_busy;
    assign bus.tick    = w_tick;
    assign bus.done    = w_done;
    assign bus.err     = r_err;
endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer driving a behavioural up-counter.
module tb_counter_sequencer;
    localparam int N = 8;

    // Output vector order: {cnt_en, cnt_clr, busy, tick, done, err}
    localparam logic [5:0] O_IDLE   = 6'b000000;
    localparam logic [5:0] O_CLEAR  = 6'b011000;
    localparam logic [5:0] O_EN     = 6'b101000;
    localparam logic [5:0] O_TICKOS = 6'b001100;
    localparam logic [5:0] O_TICKPR = 6'b011100;
    localparam logic [5:0] O_DONE   = 6'b000010;
    localparam logic [5:0] O_ERR    = 6'b000001;
    localparam logic [5:0] O_STOP   = 6'b001000;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    counter_sequencer_if #(.N(N)) bus ();

    counter_sequencer #(.N(N)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always @(posedge clk) begin
        if (rst)              bus.count <= '0;
        else if (bus.cnt_clr) bus.count <= '0;
        else if (bus.cnt_en)  bus.count <= bus.count + 1'b1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_o(input string tag, input logic [5:0] exp);
        logic [5:0] o;
        o = {bus.cnt_en, bus.cnt_clr, bus.busy, bus.tick, bus.done, bus.err};
        chk(tag, {26'b0, o}, {26'b0, exp});
    endtask

    task automatic chk_cnt(input string tag, input int exp);
        chk(tag, {24'b0, bus.count}, 32'(exp));
    endtask

    task automatic do_start(input logic [N-1:0] p, input logic per);
        bus.period   = p;
        bus.periodic = per;
        bus.start    = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.stop     = 1'b0;
        bus.period   = '0;
        bus.periodic = 1'b0;
        step();
        step();
        chk_o("reset_outs", O_IDLE);
        chk_cnt("reset_count", 0);
        rst = 1'b0;
        step();
        chk_o("idle_outs", O_IDLE);

        // one-shot P=5
        do_start(8'd5, 1'b0);
        chk_o("os5_clear", O_CLEAR);
        for (int i = 0; i < 4; i++) begin
            step();
            chk_cnt("os5_count", i);
            chk_o("os5_run", O_EN);
        end
        step();
        chk_cnt("os5_count_term", 4);
        chk_o("os5_tick", O_TICKOS);
        step();
        chk_o("os5_done", O_DONE);
        chk_cnt("os5_hold_done", 4);
        step();
        chk_o("os5_idle", O_IDLE);
        chk_cnt("os5_hold_idle", 4);

        // periodic P=3, ten intervals, then stop on a terminal cycle
        do_start(8'd3, 1'b1);
        chk_o("pr3_clear", O_CLEAR);
        for (int iv = 0; iv < 10; iv++) begin
            for (int j = 0; j < 3; j++) begin
                step();
                chk_cnt("pr3_count", j);
                chk_o("pr3_outs", (j == 2) ? O_TICKPR : O_EN);
            end
        end
        bus.stop = 1'b1;
        #1;
        chk_o("pr3_stop_over_term", O_STOP);
        step();
        bus.stop = 1'b0;
        chk_o("pr3_stopped", O_IDLE);
        chk_cnt("pr3_stop_hold", 2);

        // rejected start
        bus.period = '0;
        bus.start  = 1'b1;
        step();
        bus.start = 1'b0;
        chk_o("p0_err", O_ERR);
        step();
        chk_o("p0_err_gone", O_IDLE);

        // start together with stop is ignored
        bus.period = 8'd5;
        bus.start  = 1'b1;
        bus.stop   = 1'b1;
        step();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        chk_o("startstop_ign", O_IDLE);
        step();
        chk_o("startstop_ign2", O_IDLE);

        // periodic P=1
        do_start(8'd1, 1'b1);
        chk_o("pr1_clear", O_CLEAR);
        for (int i = 0; i < 5; i++) begin
            step();
            chk_cnt("pr1_count", 0);
            chk_o("pr1_outs", O_TICKPR);
        end
        bus.stop = 1'b1;
        #1;
        chk_o("pr1_stop", O_STOP);
        step();
        bus.stop = 1'b0;
        chk_o("pr1_stopped", O_IDLE);

        // one-shot P=1
        do_start(8'd1, 1'b0);
        chk_o("os1_clear", O_CLEAR);
        step();
        chk_o("os1_tick", O_TICKOS);
        step();
        chk_o("os1_done", O_DONE);
        step();
        chk_o("os1_idle", O_IDLE);

        // one-shot P=8 aborted at count 3
        do_start(8'd8, 1'b0);
        for (int i = 0; i < 4; i++) step();
        chk_cnt("abort_at3", 3);
        bus.stop = 1'b1;
        #1;
        chk_o("abort_outs", O_STOP);
        step();
        bus.stop = 1'b0;
        chk_o("abort_idle", O_IDLE);
        chk_cnt("abort_hold", 3);
        step();
        chk_o("abort_no_done", O_IDLE);
        chk_cnt("abort_hold2", 3);

        // one-shot P=8 with a mid-run start (P=2 periodic) that must be ignored
        do_start(8'd8, 1'b0);
        step();
        step();
        bus.period   = 8'd2;
        bus.periodic = 1'b1;
        bus.start    = 1'b1;
        step();
        bus.start = 1'b0;
        chk_cnt("midstart_count", 2);
        chk_o("midstart_outs", O_EN);
        for (int i = 3; i < 7; i++) begin
            step();
            chk_cnt("midstart_run", i);
            chk_o("midstart_run_outs", O_EN);
        end
        step();
        chk_cnt("midstart_term", 7);
        chk_o("midstart_tick", O_TICKOS);
        step();
        chk_o("midstart_done", O_DONE);
        step();
        chk_o("midstart_idle", O_IDLE);

        // reset in the middle of a periodic P=6 run
        do_start(8'd6, 1'b1);
        for (int i = 0; i < 3; i++) step();
        chk_cnt("rstmid_count", 2);
        rst = 1'b1;
        step();
        chk_o("rstmid_outs", O_IDLE);
        chk_cnt("rstmid_cnt_reset", 0);
        rst = 1'b0;
        do_start(8'd4, 1'b0);
        chk_o("fresh4_clear", O_CLEAR);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_cnt("fresh4_count", i);
            chk_o("fresh4_run", O_EN);
        end
        step();
        chk_cnt("fresh4_term", 3);
        chk_o("fresh4_tick", O_TICKOS);
        step();
        chk_o("fresh4_done", O_DONE);
        step();
        chk_o("fresh4_idle", O_IDLE);

        // maximum period: terminal at 254, counter never wraps
        do_start(8'd255, 1'b0);
        chk_o("max_clear", O_CLEAR);
        for (int i = 0; i < 254; i++) begin
            step();
            chk_cnt("max_count", i);
            chk_o("max_run", O_EN);
        end
        step();
        chk_cnt("max_term", 254);
        chk_o("max_tick", O_TICKOS);
        step();
        chk_o("max_done", O_DONE);
        chk_cnt("max_hold", 254);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
